instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Upstream stage of the control FSM. Holds the PC and fetches 32-bit instructions
//   from instruction memory over a req/ack handshake. Presents the instruction and
//   OpCode (instr[31:26]) to the control FSM. Consumes Jump/Branch/stop from the FSM
//   and the ALU zero flag to compute the next PC. Single clock domain.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded at reset
//   ACK_TIMEOUT  16             max cycles imem_req may stay high without imem_ack (>=2)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   imem_req     out  1   fetch request; held high until imem_ack
//   imem_addr    out  32  fetch address (= pc), stable while imem_req high
//   imem_ack     in   1   memory accepts request; imem_rdata valid same cycle
//   imem_rdata   in   32  instruction word from memory
//   instr        out  32  registered instruction
//   OpCode       out  6   instr[31:26], to control FSM
//   instr_valid  out  1   1-cycle pulse: instr/OpCode valid, control inputs sampled
//   pc           out  32  current PC
//   pc_plus4     out  32  pc + 4 (mod 2^32)
//   stop         in   1   from FSM: halt fetching
//   Jump         in   1   from FSM: take jump target
//   Branch       in   1   from FSM: conditional branch
//   zero         in   1   ALU zero flag, qualifies Branch
//   halted       out  1   high while in HALT
//   fetch_err    out  1   sticky: ack timeout occurred
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, pc=RESET_PC, instr=0, imem_req=0,
//     instr_valid=0, halted=0, fetch_err=0, wait counter=0. Reset mid-transaction
//     aborts it immediately; no instr_valid is produced for it.
//   States: IDLE -> REQ -> EXEC -> REQ ... ; HALT terminal until reset.
//   IDLE : one cycle after reset release; -> REQ (or HALT if stop=1).
//   REQ  : imem_req=1, imem_addr=pc. Counter increments each cycle without ack.
//          imem_ack=1: instr<=imem_rdata, counter cleared, -> EXEC.
//          Counter reaches ACK_TIMEOUT-1 with no ack: fetch_err<=1, -> HALT.
//          stop=1 while in REQ: latched; transaction still completes on ack, the
//          word is discarded (no instr_valid), -> HALT.
//   EXEC : instr_valid=1 for exactly this cycle; Jump/Branch/zero/stop sampled here.
//          Next PC priority: stop (pc unchanged, -> HALT) > Jump >
//          Branch&zero > pc+4. Otherwise -> REQ.
//          jump target   = {pc_plus4[31:28], instr[25:0], 2'b00}
//          branch target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
//          All PC arithmetic is 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 -> 0).
//          Jump and Branch both high: Jump wins. Branch with zero=0: pc+4.
//   HALT : imem_req=0, instr_valid=0, halted=1, pc frozen; inputs ignored.
//   Latency: ack with zero wait -> instr_valid next cycle; minimum 2 cycles per
//     instruction (REQ, EXEC). imem_req low during EXEC.
//   pc_plus4 combinational from pc; OpCode combinational from instr.
// TESTING
//   1 Reset, memory acks immediately, words 0x2000_0001.. -> imem_addr 0,4,8,C;
//     instr_valid every 2nd cycle; OpCode=6'h08.
//   2 At pc=0x40, instr=0x0800_0100 with Jump=1 -> next imem_addr=0x0000_0400.
//   3 At pc=0x10, instr imm=16'hFFFE, Branch=1: zero=1 -> next pc=0x0C; zero=0 -> 0x14.
//   4 Memory withholds ack 16 cycles -> fetch_err=1, halted=1, imem_req=0, pc unchanged.
//   5 stop=1 during EXEC at pc=0x20 -> halted=1, pc stays 0x20, no further imem_req;
//     stop during REQ -> word discarded, no instr_valid, halted=1.
//   6 rst low during REQ with 3-cycle wait -> imem_req=0 at once; after release
//     imem_addr=RESET_PC, fetch_err=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack,
// and steers the next PC from the control FSM's Jump/Branch/stop.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stop,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        zero,
  output logic        halted,
  output logic        fetch_err
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EXEC,
    HALT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   pc_nx;
  logic [31:0]   instr_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          stop_lat;
  logic          stop_lat_nx;
  logic          err_nx;
  logic [31:0]   jmp_tgt;
  logic [31:0]   br_tgt;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign OpCode      = instr[31:26];
  assign imem_req    = (state == REQ);
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

  assign jmp_tgt = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign br_tgt  = pc_plus4
                 + {{14{instr[15]}}, instr[15:0], 2'b00};

  // State, PC, fetched word, wait counter and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= 32'd0;
      cnt       <= '0;
      stop_lat  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      instr     <= instr_nx;
      cnt       <= cnt_nx;
      stop_lat  <= stop_lat_nx;
      fetch_err <= err_nx;
    end
  end

  // Next state: handshake, timeout, stop handling and next-PC choice.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    instr_nx    = instr;
    cnt_nx      = cnt;
    stop_lat_nx = stop_lat;
    err_nx      = fetch_err;
    unique case (state)
      IDLE: begin
        state_nx = stop ? HALT : REQ;
      end
      REQ: begin
        if (imem_ack) begin
          cnt_nx      = '0;
          stop_lat_nx = 1'b0;
          if (stop || stop_lat) begin
            state_nx = HALT;
          end else begin
            instr_nx = imem_rdata;
            state_nx = EXEC;
          end
        end else if (cnt == CNT_LAST) begin
          cnt_nx      = '0;
          stop_lat_nx = 1'b0;
          err_nx      = 1'b1;
          state_nx    = HALT;
        end else begin
          cnt_nx      = cnt + CW'(1);
          stop_lat_nx = stop_lat | stop;
        end
      end
      EXEC: begin
        if (stop) begin
          state_nx = HALT;
        end else begin
          state_nx = REQ;
          if (Jump) begin
            pc_nx = jmp_tgt;
          end else if (Branch && zero) begin
            pc_nx = br_tgt;
          end else begin
            pc_nx = pc_plus4;
          end
        end
      end
      HALT: begin
        state_nx = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: memory/control driver
// with a PC reference model, plus an independent instr_valid monitor.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stop;
  logic        Jump;
  logic        Branch;
  logic        zero;
  logic        halted;
  logic        fetch_err;

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .OpCode     (OpCode),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .stop       (stop),
    .Jump       (Jump),
    .Branch     (Branch),
    .zero       (zero),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  ctl_q[$];
  logic [31:0] word_ovr[logic [31:0]];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] seed;
  logic [31:0] model_pc;
  bit          halt_exp, err_exp, exec_now;
  bit          req_active, stop_seen, halt_chk, no_ack;
  int          n_exec, wait_left, req_cycles;
  int          max_wait, fixed_wait, p_stop, req_stop_at;

  logic [3:0]  dc;
  logic [31:0] dw, dp4;
  int          doff;
  exp_t        de, me;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (word_ovr.exists(a)) return word_ovr[a];
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic bit rnd(input int p);
    return $urandom_range(0, 999) < p;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Memory responder, control-input source and reference PC model.
  initial forever begin
    @(negedge clk);
    imem_ack   = 1'b0;
    stop       = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    zero       = 1'($urandom);
    imem_rdata = $urandom;
    if (rst) begin
      if (halt_chk) begin
        halt_chk = 0;
        chk("halt_entry", {31'b0, halted}, 32'd1);
        chk("halt_entry_req", {31'b0, imem_req}, 32'd0);
      end
      if (exec_now) begin
        exec_now = 0;
        dw  = word_of(model_pc);
        dp4 = model_pc + 32'd4;
        if (ctl_q.size() > 0) dc = ctl_q.pop_front();
        else dc = {rnd(p_stop), $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0, 1'($urandom)};
        {stop, Jump, Branch, zero} = dc;
        n_exec++;
        if (stop) begin
          halt_exp = 1;
          halt_chk = 1;
        end else if (Jump) begin
          model_pc = {dp4[31:28], dw[25:0], 2'b00};
        end else if (Branch && zero) begin
          doff     = $signed(dw[15:0]);
          doff     = doff * 4;
          model_pc = dp4 + doff;
        end else begin
          model_pc = dp4;
        end
      end else if (imem_req && !halt_exp) begin
        chk("imem_addr", imem_addr, model_pc);
        if (!req_active) begin
          req_active = 1;
          req_cycles = 0;
          stop_seen  = 0;
          if (no_ack) wait_left = 1000;
          else if (fixed_wait >= 0) wait_left = fixed_wait;
          else wait_left = int'($urandom_range(0, max_wait));
        end
        req_cycles++;
        stop = rnd(p_stop) || (n_exec == req_stop_at);
        if (stop) stop_seen = 1;
        if (wait_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = word_of(imem_addr);
          req_active = 0;
          if (stop_seen) begin
            halt_exp = 1;
            halt_chk = 1;
          end else begin
            de.cyc  = cyc + 1;
            de.pc   = model_pc;
            de.word = word_of(model_pc);
            exp_q.push_back(de);
            exec_now = 1;
          end
        end else begin
          wait_left--;
          if (req_cycles == ACK_TIMEOUT) begin
            halt_exp   = 1;
            err_exp    = 1;
            halt_chk   = 1;
            req_active = 0;
          end
        end
      end
    end
  end

  // Monitor: every instr_valid must match the next scoreboard entry.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL valid_unexpected: got instr_valid at pc %h, expected none", pc);
        end else begin
          me = exp_q.pop_front();
          chk("valid_cycle", cyc, me.cyc);
          chk("pc", pc, me.pc);
          chk("instr", instr, me.word);
          chk("opcode", {26'b0, OpCode}, {26'b0, me.word[31:26]});
          chk("pc_plus4", pc_plus4, me.pc + 32'd4);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        me = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL valid_missing: got no instr_valid, expected one for pc %h", me.pc);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    #1;
    exp_q.delete();
    ctl_q.delete();
    word_ovr.delete();
    model_pc    = RESET_PC;
    halt_exp    = 0;
    err_exp     = 0;
    exec_now    = 0;
    req_active  = 0;
    stop_seen   = 0;
    halt_chk    = 0;
    n_exec      = 0;
    fixed_wait  = -1;
    max_wait    = 0;
    p_stop      = 0;
    no_ack      = 0;
    req_stop_at = -1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_until(input int n);
    int c;
    c = 0;
    while (!halt_exp && n_exec < n && c < 3000) begin
      @(posedge clk);
      c++;
    end
    if (c >= 3000) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: got %0d instructions, expected %0d", n_exec, n);
    end
  endtask

  task automatic wait_req();
    int c;
    c = 0;
    #1;
    while (!imem_req && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!imem_req) begin
      tests++;
      fails++;
      $display("FAIL wait_req: got no imem_req, expected one within 50 cycles");
    end
  endtask

  task automatic check_halt();
    repeat (4) @(posedge clk);
    #1;
    chk("halted", {31'b0, halted}, 32'd1);
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    chk("halt_pc", pc, model_pc);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, err_exp});
  endtask

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    stop       = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    zero       = 1'b0;
    seed       = $urandom;

    // Sequential fetch, zero-wait memory, opcode 0x08.
    do_reset();
    fixed_wait = 0;
    for (int i = 0; i < 4; i++) begin
      word_ovr[32'(i * 4)] = 32'h2000_0001 + 32'(i);
      ctl_q.push_back(4'b0000);
    end
    run_until(4);

    // Jump at pc 0x40.
    do_reset();
    fixed_wait = 0;
    for (int i = 0; i < 16; i++) ctl_q.push_back(4'b0000);
    ctl_q.push_back(4'b0100);
    word_ovr[32'h40] = 32'h0800_0100;
    run_until(17);
    wait_req();
    chk("jump_target", imem_addr, 32'h0000_0400);

    // Backward branch at pc 0x10, taken then not taken.
    do_reset();
    max_wait = 2;
    for (int i = 0; i < 4; i++) ctl_q.push_back(4'b0000);
    ctl_q.push_back(4'b0011);
    ctl_q.push_back(4'b0000);
    ctl_q.push_back(4'b0010);
    word_ovr[32'h10] = 32'h1000_FFFE;
    run_until(5);
    wait_req();
    chk("branch_taken", imem_addr, 32'h0000_000C);
    run_until(7);
    wait_req();
    chk("branch_not_taken", imem_addr, 32'h0000_0014);

    // PC wraps from 0xFFFF_FFFC to 0.
    do_reset();
    fixed_wait = 1;
    word_ovr[32'h0] = 32'h1000_FFFE;
    ctl_q.push_back(4'b0011);
    ctl_q.push_back(4'b0000);
    run_until(1);
    wait_req();
    chk("branch_to_top", imem_addr, 32'hFFFF_FFFC);
    run_until(2);
    wait_req();
    chk("pc_wrap", imem_addr, 32'h0000_0000);

    // Ack withheld: timeout sets fetch_err and halts.
    do_reset();
    no_ack = 1;
    run_until(99);
    check_halt();
    chk("timeout_pc", pc, RESET_PC);

    // Reset in the middle of a waiting request.
    do_reset();
    fixed_wait = 3;
    wait_req();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_abort_req", {31'b0, imem_req}, 32'd0);
    do_reset();
    wait_req();
    chk("post_rst_addr", imem_addr, RESET_PC);
    chk("post_rst_err", {31'b0, fetch_err}, 32'd0);
    run_until(3);

    // Stop during EXEC at pc 0x20.
    do_reset();
    max_wait = 1;
    for (int i = 0; i < 8; i++) ctl_q.push_back(4'b0000);
    ctl_q.push_back(4'b1000);
    run_until(99);
    check_halt();
    chk("stop_pc", pc, 32'h0000_0020);

    // Stop during REQ: word discarded, no instr_valid.
    do_reset();
    fixed_wait  = 2;
    req_stop_at = 2;
    ctl_q.push_back(4'b0000);
    ctl_q.push_back(4'b0000);
    run_until(99);
    check_halt();
    chk("stop_req_pc", pc, 32'h0000_0008);

    // Randomized segments.
    for (int s = 0; s < 8; s++) begin
      do_reset();
      max_wait = int'($urandom_range(0, 4));
      p_stop   = 10;
      run_until(50);
      if (halt_exp) check_halt();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
